// File: rtl/sample_scheduler.sv
// Round-robin acquisition controller: on each sample tick, walks the enabled channels,
// issues one conversion request per channel, and forwards each result tagged with its channel.
module sample_scheduler #(
   parameter int NUM_CH  = 4,
   parameter int TIMEOUT = 15,
   localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int WAIT_W = $clog2(TIMEOUT + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic [15:0]       period,
   input  logic [NUM_CH-1:0] ch_mask,
   input  logic              clear_err,
   output logic              conv_req,
   output logic [CH_W-1:0]   conv_ch,
   input  logic              conv_ack,
   input  logic [7:0]        conv_data,
   output logic              smp_valid,
   output logic [CH_W-1:0]   smp_ch,
   output logic [7:0]        smp_data,
   output logic              round_done,
   output logic              busy,
   output logic              overrun,
   output logic [NUM_CH-1:0] timeout_err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SCAN,
      S_REQ,
      S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [15:0]         tcnt_q, tcnt_d;
   logic [15:0]         period_m1;
   logic                tick;
   logic [NUM_CH-1:0]   mask_q, mask_d;
   logic [CH_W-1:0]     ptr_q, ptr_d;
   logic [WAIT_W-1:0]   wcnt_q, wcnt_d;
   logic                conv_req_q, conv_req_d;
   logic [CH_W-1:0]     conv_ch_q, conv_ch_d;
   logic                smp_valid_q, smp_valid_d;
   logic [CH_W-1:0]     smp_ch_q, smp_ch_d;
   logic [7:0]          smp_data_q, smp_data_d;
   logic                round_done_q, round_done_d;
   logic                busy_q, busy_d;
   logic                overrun_q, overrun_d;
   logic [NUM_CH-1:0]   timeout_q, timeout_d;
   logic                overrun_set;
   logic [NUM_CH-1:0]   timeout_set;
   logic                last_ch;
   logic                wait_expired;

   // A zero period behaves like period 1, i.e. a tick on every enabled cycle.
   always_comb begin
      period_m1 = (period == 16'd0) ? 16'd0 : period - 16'd1;
      tick      = 1'b0;
      tcnt_d    = 16'd0;
      if (enable) begin
         if (tcnt_q >= period_m1) begin
            tick = 1'b1;
         end else begin
            tcnt_d = tcnt_q + 16'd1;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      mask_d       = mask_q;
      ptr_d        = ptr_q;
      wcnt_d       = wcnt_q;
      conv_req_d   = conv_req_q;
      conv_ch_d    = conv_ch_q;
      smp_valid_d  = 1'b0;
      smp_ch_d     = smp_ch_q;
      smp_data_d   = smp_data_q;
      overrun_set  = 1'b0;
      timeout_set  = '0;
      last_ch      = (ptr_q == CH_W'(NUM_CH - 1));
      wait_expired = (wcnt_q == WAIT_W'(TIMEOUT - 1));

      case (state_q)
         S_IDLE: begin
            if (tick) begin
               mask_d  = ch_mask;
               ptr_d   = '0;
               state_d = S_SCAN;
            end
         end
         S_SCAN: begin
            if (mask_q[ptr_q]) begin
               state_d    = S_REQ;
               wcnt_d     = '0;
               conv_req_d = 1'b1;
               conv_ch_d  = ptr_q;
            end else if (last_ch) begin
               state_d = S_DONE;
            end else begin
               ptr_d = ptr_q + 1'b1;
            end
         end
         S_REQ: begin
            // An ack on the final wait cycle still counts as a good sample.
            if (conv_ack || wait_expired) begin
               if (conv_ack) begin
                  smp_valid_d = 1'b1;
                  smp_ch_d    = ptr_q;
                  smp_data_d  = conv_data;
               end else begin
                  timeout_set[ptr_q] = 1'b1;
               end
               conv_req_d = 1'b0;
               if (last_ch) begin
                  state_d = S_DONE;
               end else begin
                  ptr_d   = ptr_q + 1'b1;
                  state_d = S_SCAN;
               end
            end else begin
               wcnt_d = wcnt_q + 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (tick && (state_q != S_IDLE)) begin
         overrun_set = 1'b1;
      end

      round_done_d = (state_d == S_DONE);
      busy_d       = (state_d != S_IDLE);
      overrun_d    = (overrun_q & ~clear_err) | overrun_set;
      timeout_d    = (timeout_q & ~{NUM_CH{clear_err}}) | timeout_set;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         tcnt_q       <= 16'd0;
         mask_q       <= '0;
         ptr_q        <= '0;
         wcnt_q       <= '0;
         conv_req_q   <= 1'b0;
         conv_ch_q    <= '0;
         smp_valid_q  <= 1'b0;
         smp_ch_q     <= '0;
         smp_data_q   <= 8'd0;
         round_done_q <= 1'b0;
         busy_q       <= 1'b0;
         overrun_q    <= 1'b0;
         timeout_q    <= '0;
      end else begin
         state_q      <= state_d;
         tcnt_q       <= tcnt_d;
         mask_q       <= mask_d;
         ptr_q        <= ptr_d;
         wcnt_q       <= wcnt_d;
         conv_req_q   <= conv_req_d;
         conv_ch_q    <= conv_ch_d;
         smp_valid_q  <= smp_valid_d;
         smp_ch_q     <= smp_ch_d;
         smp_data_q   <= smp_data_d;
         round_done_q <= round_done_d;
         busy_q       <= busy_d;
         overrun_q    <= overrun_d;
         timeout_q    <= timeout_d;
      end
   end

   assign conv_req    = conv_req_q;
   assign conv_ch     = conv_ch_q;
   assign smp_valid   = smp_valid_q;
   assign smp_ch      = smp_ch_q;
   assign smp_data    = smp_data_q;
   assign round_done  = round_done_q;
   assign busy        = busy_q;
   assign overrun     = overrun_q;
   assign timeout_err = timeout_q;

endmodule

// File: tb/tb_sample_scheduler.sv
// Bench for sample_scheduler: randomized converter and inputs, checked cycle by cycle against
// a round-schedule model built from per-channel request lengths.
module tb_sample_scheduler;
   localparam int NUM_CH  = 4;
   localparam int TIMEOUT = 15;
   localparam int MAXC    = 8192;
   localparam int NEVER   = 255;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        enable = 1'b0;
   logic [15:0] period = 16'd0;
   logic [3:0]  ch_mask = 4'd0;
   logic        clear_err = 1'b0;
   logic        conv_req;
   logic [1:0]  conv_ch;
   logic        conv_ack = 1'b0;
   logic [7:0]  conv_data = 8'd0;
   logic        smp_valid;
   logic [1:0]  smp_ch;
   logic [7:0]  smp_data;
   logic        round_done;
   logic        busy;
   logic        overrun;
   logic [3:0]  timeout_err;

   sample_scheduler #(.NUM_CH(NUM_CH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .enable(enable), .period(period), .ch_mask(ch_mask),
      .clear_err(clear_err), .conv_req(conv_req), .conv_ch(conv_ch), .conv_ack(conv_ack),
      .conv_data(conv_data), .smp_valid(smp_valid), .smp_ch(smp_ch), .smp_data(smp_data),
      .round_done(round_done), .busy(busy), .overrun(overrun), .timeout_err(timeout_err)
   );

   initial forever #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Expected per-cycle outputs, filled in whole rounds at a time when a round starts.
   bit       exp_req[MAXC];
   bit [1:0] exp_ch[MAXC];
   bit       exp_sv[MAXC];
   bit [1:0] exp_sch[MAXC];
   bit [7:0] exp_sd[MAXC];
   bit       exp_rd[MAXC];
   bit       exp_busy[MAXC];
   bit [3:0] exp_to_set[MAXC];
   int       m_cnt = 0;
   int       busy_until = -10;
   bit       m_ovr = 1'b0;
   bit [3:0] m_to = 4'd0;
   int       lat[NUM_CH];
   bit [7:0] cdata[NUM_CH];
   int       age = 0;

   task automatic start_round(input int k0, input logic [3:0] m);
      int s, len, e;
      bit ok;
      s = k0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         if (m[ch]) begin
            ok  = (lat[ch] != NEVER) && (lat[ch] + 1 <= TIMEOUT);
            len = ok ? lat[ch] + 1 : TIMEOUT;
            for (int c = s + 1; c <= s + len; c++) begin
               exp_req[c] = 1'b1;
               exp_ch[c]  = 2'(ch);
            end
            e = s + len + 1;
            if (ok) begin
               exp_sv[e]  = 1'b1;
               exp_sch[e] = 2'(ch);
               exp_sd[e]  = cdata[ch];
            end else begin
               exp_to_set[e][ch] = 1'b1;
            end
            s = e;
         end else begin
            s = s + 1;
         end
      end
      exp_rd[s] = 1'b1;
      for (int c = k0; c <= s; c++) exp_busy[c] = 1'b1;
      busy_until = s;
   endtask

   // Model: advances at each rising edge using the inputs held over the preceding cycle.
   initial forever begin
      int k, pm1;
      bit tick, ovr_set;
      @(posedge clk);
      cyc = cyc + 1;
      k = cyc;
      if (rst) begin
         m_cnt = 0;
         busy_until = -10;
         m_ovr = 1'b0;
         m_to = 4'd0;
         for (int c = k; c < MAXC; c++) begin
            exp_req[c] = 1'b0; exp_sv[c] = 1'b0; exp_rd[c] = 1'b0;
            exp_busy[c] = 1'b0; exp_to_set[c] = 4'd0;
         end
      end else begin
         tick = 1'b0;
         ovr_set = 1'b0;
         pm1 = (period == 16'd0) ? 0 : int'(period) - 1;
         if (enable) begin
            if (m_cnt >= pm1) begin
               tick = 1'b1;
               m_cnt = 0;
            end else begin
               m_cnt = m_cnt + 1;
            end
         end else begin
            m_cnt = 0;
         end
         if (tick) begin
            if (busy_until < k - 1) start_round(k, ch_mask);
            else ovr_set = 1'b1;
         end
         m_ovr = (m_ovr & ~clear_err) | ovr_set;
         m_to = (m_to & ~{4{clear_err}}) | exp_to_set[k];
      end
   end

   // Checker: compares every output on the falling edge.
   initial begin
      bit [1:0] h_ch;
      bit [7:0] h_data;
      h_ch = 2'd0;
      h_data = 8'd0;
      forever begin
         @(negedge clk);
         if (rst) begin
            h_ch = 2'd0;
            h_data = 8'd0;
         end else if (exp_sv[cyc]) begin
            h_ch = exp_sch[cyc];
            h_data = exp_sd[cyc];
         end
         check("busy", 32'(busy), 32'(exp_busy[cyc]));
         check("conv_req", 32'(conv_req), 32'(exp_req[cyc]));
         if (exp_req[cyc]) check("conv_ch", 32'(conv_ch), 32'(exp_ch[cyc]));
         check("smp_valid", 32'(smp_valid), 32'(exp_sv[cyc]));
         check("smp_ch", 32'(smp_ch), 32'(h_ch));
         check("smp_data", 32'(smp_data), 32'(h_data));
         check("round_done", 32'(round_done), 32'(exp_rd[cyc]));
         check("overrun", 32'(overrun), 32'(m_ovr));
         check("timeout_err", 32'(timeout_err), 32'(m_to));
      end
   end

   task automatic pick_conv(input int mode);
      int r;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         case (mode)
            0: begin lat[ch] = 0; cdata[ch] = 8'(8'h10 + ch); end
            1: begin lat[ch] = $urandom_range(0, 3); cdata[ch] = 8'($urandom); end
            2: begin lat[ch] = (ch == 1) ? NEVER : 0; cdata[ch] = 8'(8'h10 + ch); end
            3: begin lat[ch] = 2; cdata[ch] = 8'($urandom); end
            default: begin
               r = $urandom_range(0, 17);
               lat[ch] = (r == 17) ? NEVER : r;
               cdata[ch] = 8'($urandom);
            end
         endcase
      end
   endtask

   // One falling edge: refresh converter behaviour between rounds, then drive ack/data.
   task automatic drive_cycle(input int mode);
      @(negedge clk);
      if (busy_until < cyc) pick_conv(mode);
      if (conv_req) begin
         age = age + 1;
         conv_data = cdata[conv_ch];
         conv_ack = (lat[conv_ch] != NEVER) && (age > lat[conv_ch]);
      end else begin
         age = 0;
         conv_ack = ($urandom_range(0, 3) == 0);
         conv_data = 8'($urandom);
      end
   endtask

   initial begin
      rst = 1'b1;
      pick_conv(0);
      repeat (3) drive_cycle(0);
      rst = 1'b0;

      // Full mask, immediate ack, period 20.
      enable = 1'b1;
      period = 16'd20;
      ch_mask = 4'hF;
      repeat (120) drive_cycle(0);

      // Mask 0101 latched at round start, widened to 1111 while busy.
      for (int i = 0; i < 60; i++) begin
         drive_cycle(0);
         ch_mask = busy ? 4'hF : 4'h5;
      end

      // Random masks every cycle, random short ack latencies.
      for (int i = 0; i < 400; i++) begin
         drive_cycle(1);
         if (i % 100 == 0) period = 16'($urandom_range(10, 30));
         ch_mask = 4'($urandom);
      end

      // Channel 1 never acks; then clear the sticky error.
      enable = 1'b0;
      repeat (30) drive_cycle(2);
      enable = 1'b1;
      period = 16'd40;
      ch_mask = 4'h3;
      repeat (70) drive_cycle(2);
      enable = 1'b0;
      repeat (5) drive_cycle(2);
      clear_err = 1'b1;
      drive_cycle(2);
      clear_err = 1'b0;
      repeat (5) drive_cycle(2);

      // Period too short for a slow converter: overrun.
      period = 16'd5;
      ch_mask = 4'hF;
      enable = 1'b1;
      repeat (80) drive_cycle(3);

      // Asynchronous reset while a request is outstanding.
      period = 16'd12;
      for (int i = 0; i < 100; i++) begin
         if (conv_req) break;
         drive_cycle(0);
      end
      check("wait_conv_req", 32'(conv_req), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("rst_conv_req", 32'(conv_req), 32'd0);
      check("rst_conv_ch", 32'(conv_ch), 32'd0);
      check("rst_smp_valid", 32'(smp_valid), 32'd0);
      check("rst_smp_ch", 32'(smp_ch), 32'd0);
      check("rst_smp_data", 32'(smp_data), 32'd0);
      check("rst_round_done", 32'(round_done), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      check("rst_timeout_err", 32'(timeout_err), 32'd0);
      repeat (2) drive_cycle(0);
      rst = 1'b0;
      repeat (60) drive_cycle(0);

      // Period 0 with an empty mask: scan-only rounds.
      enable = 1'b0;
      repeat (3) drive_cycle(0);
      period = 16'd0;
      ch_mask = 4'h0;
      enable = 1'b1;
      repeat (40) drive_cycle(0);

      // Fully random operation.
      for (int i = 0; i < 3000; i++) begin
         drive_cycle(4);
         enable = ($urandom_range(0, 19) != 0);
         clear_err = ($urandom_range(0, 15) == 0);
         if (i % 50 == 0) period = 16'($urandom_range(0, 30));
         ch_mask = 4'($urandom);
      end
      clear_err = 1'b0;
      enable = 1'b0;
      repeat (30) drive_cycle(4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
